// File: rtl/iref_seq.sv
// Multi-channel current-reference power-up sequencer with a memory-mapped CPU slave port.
// Each channel: release pd, pulse charge, settle, then flag done and raise a pending interrupt.
module iref_seq #(
   parameter int unsigned N_CH   = 4,
   parameter int unsigned ADDR_W = 3,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] wdata,
   input  logic              wstrb,
   output logic [DATA_W-1:0] rdata,
   output logic              ready,
   output logic [N_CH-1:0]   pd,
   output logic [N_CH-1:0]   charge,
   output logic              irq
);

   localparam logic [ADDR_W-1:0] A_PD      = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] A_START   = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] A_CHG_LEN = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] A_SET_LEN = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] A_IRQ_EN  = ADDR_W'(5);
   localparam logic [ADDR_W-1:0] A_IRQ_PND = ADDR_W'(6);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CHARGE,
      S_SETTLE,
      S_ON
   } ch_state_t;

   ch_state_t         state_q [N_CH];
   ch_state_t         state_d [N_CH];
   logic [CNT_W-1:0]  cnt_q   [N_CH];
   logic [CNT_W-1:0]  cnt_d   [N_CH];

   logic [CNT_W-1:0]  chg_len;
   logic [CNT_W-1:0]  set_len;
   logic [CNT_W-1:0]  chg_load;
   logic [CNT_W-1:0]  set_load;
   logic [N_CH-1:0]   irq_en;
   logic [N_CH-1:0]   irq_pend;
   logic [N_CH-1:0]   set_pend;
   logic [N_CH-1:0]   done;
   logic [N_CH-1:0]   busy;

   logic              accept;
   logic              wr;
   logic [N_CH-1:0]   abort_mask;
   logic [N_CH-1:0]   start_mask;
   logic [N_CH-1:0]   w1c_mask;
   logic [DATA_W-1:0] rd_val;
   logic              unused_wdata;

   assign unused_wdata = ^wdata;

   // A held valid re-accepts every other cycle because ready blocks acceptance.
   assign accept = valid & ~ready;
   assign wr     = accept & wstrb;

   assign abort_mask = (wr && address == A_PD)      ? wdata[N_CH-1:0] : '0;
   assign start_mask = (wr && address == A_START)   ? wdata[N_CH-1:0] : '0;
   assign w1c_mask   = (wr && address == A_IRQ_PND) ? wdata[N_CH-1:0] : '0;

   assign chg_load = (chg_len == '0) ? CNT_W'(1) : chg_len;
   assign set_load = (set_len == '0) ? CNT_W'(1) : set_len;

   always_comb begin
      set_pend = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            S_IDLE, S_ON: begin
               if (start_mask[i]) begin
                  state_d[i] = S_CHARGE;
                  cnt_d[i]   = chg_load;
               end
            end
            S_CHARGE: begin
               if (cnt_q[i] == CNT_W'(1)) begin
                  state_d[i] = S_SETTLE;
                  cnt_d[i]   = set_load;
               end else begin
                  cnt_d[i] = cnt_q[i] - CNT_W'(1);
               end
            end
            S_SETTLE: begin
               if (cnt_q[i] == CNT_W'(1)) begin
                  state_d[i]  = S_ON;
                  cnt_d[i]    = '0;
                  set_pend[i] = 1'b1;
               end else begin
                  cnt_d[i] = cnt_q[i] - CNT_W'(1);
               end
            end
            default: begin
               state_d[i] = S_IDLE;
               cnt_d[i]   = '0;
            end
         endcase
         // Abort overrides everything, including a completion on the same edge.
         if (abort_mask[i]) begin
            state_d[i]  = S_IDLE;
            cnt_d[i]    = '0;
            set_pend[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < N_CH; i++) begin
            state_q[i] <= S_IDLE;
            cnt_q[i]   <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < N_CH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   always_comb begin
      pd     = '0;
      charge = '0;
      done   = '0;
      busy   = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         pd[i]     = (state_q[i] == S_IDLE);
         charge[i] = (state_q[i] == S_CHARGE);
         done[i]   = (state_q[i] == S_ON);
         busy[i]   = (state_q[i] == S_CHARGE) || (state_q[i] == S_SETTLE);
      end
   end

   always_comb begin
      rd_val = '0;
      case (address)
         A_PD:      rd_val[N_CH-1:0]   = pd;
         A_CHG_LEN: rd_val[CNT_W-1:0]  = chg_len;
         A_SET_LEN: rd_val[CNT_W-1:0]  = set_len;
         A_STATUS:  rd_val[2*N_CH-1:0] = {busy, done};
         A_IRQ_EN:  rd_val[N_CH-1:0]   = irq_en;
         A_IRQ_PND: rd_val[N_CH-1:0]   = irq_pend;
         default:   rd_val             = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ready    <= 1'b0;
         rdata    <= '0;
         chg_len  <= CNT_W'(16);
         set_len  <= CNT_W'(64);
         irq_en   <= '0;
         irq_pend <= '0;
      end else begin
         ready    <= accept;
         rdata    <= accept ? rd_val : '0;
         irq_pend <= (irq_pend & ~w1c_mask) | set_pend;
         if (wr) begin
            case (address)
               A_CHG_LEN: chg_len <= wdata[CNT_W-1:0];
               A_SET_LEN: set_len <= wdata[CNT_W-1:0];
               A_IRQ_EN:  irq_en  <= wdata[N_CH-1:0];
               default: ;
            endcase
         end
      end
   end

   assign irq = |(irq_pend & irq_en);

endmodule

// File: tb/tb_iref_seq.sv
// Directed bench for iref_seq: bus register access, per-channel sequencing timing, abort and reset.
module tb_iref_seq;

   logic        clk;
   logic        rst;
   logic        valid;
   logic [2:0]  address;
   logic [31:0] wdata;
   logic        wstrb;
   logic [31:0] rdata;
   logic        ready;
   logic [3:0]  pd;
   logic [3:0]  charge;
   logic        irq;

   int total;
   int bad;

   iref_seq #(.N_CH(4), .ADDR_W(3), .DATA_W(32), .CNT_W(16)) dut (
      .clk     (clk),
      .rst     (rst),
      .valid   (valid),
      .address (address),
      .wdata   (wdata),
      .wstrb   (wstrb),
      .rdata   (rdata),
      .ready   (ready),
      .pd      (pd),
      .charge  (charge),
      .irq     (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Called at a sample point (#1 after a posedge); returns at the sample point where ready=1.
   task automatic bus_op(input logic [2:0] a, input logic [31:0] d, input logic w,
                         output logic [31:0] r, output int lat);
      logic got;
      got     = 1'b0;
      lat     = 0;
      valid   = 1'b1;
      address = a;
      wdata   = d;
      wstrb   = w;
      for (int n = 0; n < 8 && !got; n++) begin
         @(posedge clk);
         #1;
         lat++;
         if (ready) got = 1'b1;
      end
      check("ready_timeout", {31'b0, got}, 32'd1);
      r     = rdata;
      valid = 1'b0;
      wstrb = 1'b0;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      logic [31:0] r;
      int lat;
      bus_op(a, d, 1'b1, r, lat);
   endtask

   task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
      logic [31:0] r;
      int lat;
      bus_op(a, 32'h0, 1'b0, r, lat);
      check(tag, r, exp);
   endtask

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic [31:0] r;
      int lat;
      total   = 0;
      bad     = 0;
      rst     = 1'b0;
      valid   = 1'b0;
      address = '0;
      wdata   = '0;
      wstrb   = 1'b0;

      // power-on reset values
      step(2);
      check("rst_pd", 32'(pd), 32'hF);
      check("rst_charge", 32'(charge), 32'h0);
      check("rst_ready", 32'(ready), 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_rdata", rdata, 32'h0);
      #3 rst = 1'b1;
      step(1);

      rd_chk("def_chg", 3'd2, 32'd16);
      rd_chk("def_set", 3'd3, 32'd64);
      wr(3'd5, 32'hFFFF_FFFF);
      rd_chk("irq_en_mask", 3'd5, 32'h0000_000F);
      wr(3'd3, 32'h0001_2345);
      rd_chk("set_trunc", 3'd3, 32'h0000_2345);

      // basic sequence: CHG=3, SET=5
      wr(3'd2, 32'd3);
      wr(3'd3, 32'd5);
      wr(3'd5, 32'd1);
      wr(3'd1, 32'd1);
      check("t2_pd", 32'(pd), 32'hE);
      fork
         begin
            for (int k = 0; k < 10; k++) begin
               check($sformatf("t2_charge_k%0d", k), 32'(charge[0]), (k < 3) ? 32'd1 : 32'd0);
               if (k == 7) check("t2_irq_early", 32'(irq), 32'd0);
               if (k == 8) check("t2_irq_done", 32'(irq), 32'd1);
               @(posedge clk);
               #1;
            end
         end
         begin
            rd_chk("t2_status_busy", 3'd4, 32'h10);
         end
      join
      rd_chk("t2_status_done", 3'd4, 32'h01);
      rd_chk("t2_pend", 3'd6, 32'h1);
      wr(3'd6, 32'h1);
      check("t2_irq_clr", 32'(irq), 32'd0);

      // abort during CHARGE
      wr(3'd2, 32'd10);
      wr(3'd1, 32'd1);
      step(3);
      check("t3_charge_pre", 32'(charge[0]), 32'd1);
      wr(3'd0, 32'd1);
      check("t3_pd_abort", 32'(pd[0]), 32'd1);
      check("t3_charge_abort", 32'(charge[0]), 32'd0);
      step(15);
      rd_chk("t3_status", 3'd4, 32'h0);
      rd_chk("t3_pend", 3'd6, 32'h0);

      // parallel start, busy re-start ignored, re-charge from ON
      wr(3'd2, 32'd3);
      wr(3'd1, 32'd5);
      check("t4_charge_par", 32'(charge), 32'h5);
      wr(3'd1, 32'd1);
      check("t4_charge_last", 32'(charge), 32'h5);
      step(1);
      check("t4_restart_ign", 32'(charge), 32'h0);
      step(8);
      rd_chk("t4_status_on", 3'd4, 32'h05);
      wr(3'd1, 32'd1);
      check("t4_recharge", 32'(charge), 32'h1);
      check("t4_pd", 32'(pd), 32'hA);
      step(12);
      rd_chk("t4_pend", 3'd6, 32'h5);

      // zero lengths clamp to one cycle each
      wr(3'd6, 32'hF);
      wr(3'd5, 32'h2);
      wr(3'd2, 32'd0);
      wr(3'd3, 32'd0);
      wr(3'd1, 32'd2);
      check("t5_charge", 32'(charge), 32'h2);
      step(1);
      check("t5_charge_end", 32'(charge), 32'h0);
      check("t5_irq_early", 32'(irq), 32'd0);
      step(1);
      check("t5_irq_done", 32'(irq), 32'd1);

      // full read map with latency check
      begin
         logic [31:0] exp_map [8];
         exp_map = '{32'h8, 32'h0, 32'h0, 32'h0, 32'h07, 32'h2, 32'h2, 32'h0};
         for (int a = 0; a < 8; a++) begin
            step(1);
            bus_op(3'(a), 32'h0, 1'b0, r, lat);
            check($sformatf("t6_rd%0d", a), r, exp_map[a]);
            check($sformatf("t6_lat%0d", a), 32'(lat), 32'd1);
         end
      end
      step(1);
      valid   = 1'b1;
      address = 3'd5;
      wstrb   = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("t6_held_k%0d", k), 32'(ready), (k % 2 == 0) ? 32'd1 : 32'd0);
      end
      valid = 1'b0;
      step(1);

      // asynchronous reset mid-CHARGE
      wr(3'd2, 32'd10);
      wr(3'd1, 32'h8);
      check("t1_charge_pre", 32'(charge), 32'h8);
      check("t1_irq_pre", 32'(irq), 32'd1);
      step(2);
      #3 rst = 1'b0;
      #1;
      check("t1_pd", 32'(pd), 32'hF);
      check("t1_charge", 32'(charge), 32'h0);
      check("t1_irq", 32'(irq), 32'd0);
      check("t1_ready", 32'(ready), 32'd0);
      #2 rst = 1'b1;
      step(1);
      rd_chk("t1_chg", 3'd2, 32'd16);
      rd_chk("t1_set", 3'd3, 32'd64);
      rd_chk("t1_status", 3'd4, 32'h0);
      rd_chk("t1_pend", 3'd6, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
